// File: rtl/priority_arbiter8_if.sv
// Request/grant bundle between requesters (master) and the 8-way arbiter (slave).
// Inputs are sampled on the clock edge; outputs are registered in the arbiter.
interface priority_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output en, req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input en, req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/priority_arbiter8.sv
// 8-way non-preemptive arbiter: 1-cycle req->gnt, grant held until done/req drop/en low/HOLD_MAX.
// Policy: fixed priority (7 highest) by default; `define ROUND_ROBIN_EN for rotating priority.
module priority_arbiter8 #(
  parameter int HOLD_MAX = 15
) (
  input logic            clk,
  input logic            rst,
  priority_arbiter8_if.slave arb
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  logic [2:0] win_id;
  logic       hold_hit;
  logic       early_rel;

`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  // Descending search starting just below the last winner; later hits override earlier ones.
  always_comb begin
    win_id = '0;
    for (int k = 7; k >= 0; k--) begin
      if (arb.req[ptr_q - 3'd1 - 3'(k)]) win_id = ptr_q - 3'd1 - 3'(k);
    end
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = 0; i < 8; i++) begin
      if (arb.req[i]) win_id = 3'(i);
    end
  end
`endif

  assign hold_hit  = (hold_q == HOLD_LIM);
  assign early_rel = arb.done || !arb.req[gnt_id_q] || !arb.en;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
`ifdef ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        hold_d      = '0;
        if (arb.en && (arb.req != 8'd0)) begin
          state_d     = GRANT;
          gnt_d       = 8'd1 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_d      = 8'd1;
`ifdef ROUND_ROBIN_EN
          ptr_d       = win_id;
`endif
        end
      end
      GRANT: begin
        if (early_rel || hold_hit) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          hold_d      = '0;
          // Only a pure hold-limit release is flagged; any other cause masks it.
          timeout_d   = hold_hit && !early_rel;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
`ifdef ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.gnt_id    = gnt_id_q;
  assign arb.gnt_valid = gnt_valid_q;
  assign arb.timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter8.sv
// Bench for priority_arbiter8: directed scenarios plus randomized traffic vs a behavioural model.
// Honours ROUND_ROBIN_EN the same way the design does.
module tb_priority_arbiter8;

  localparam int HOLD = 15;

  logic clk;
  logic rst;

  priority_arbiter8_if arb ();

  priority_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current grantee (-1 = none), cycles held, last winner, timeout flag.
  int m_id;
  int m_hold;
  int m_ptr;
  bit m_to;
  bit prev_to;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (m_ptr - k + 16) % 8;
      if (r[idx]) return idx;
    end
`else
    for (int n = 7; n >= 0; n--) begin
      if (r[n]) return n;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_id    = -1;
    m_hold  = 0;
    m_ptr   = 0;
    m_to    = 1'b0;
    prev_to = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r, input logic d);
    if (m_id < 0) begin
      m_to = 1'b0;
      if (e && r != 8'd0) begin
        m_id   = pick(r);
        m_ptr  = m_id;
        m_hold = 1;
      end
    end else begin
      bit other_cause;
      bit limit;
      other_cause = d || !r[m_id] || !e;
      limit       = (m_hold >= HOLD);
      if (other_cause || limit) begin
        m_to   = limit && !other_cause;
        m_id   = -1;
        m_hold = 0;
      end else begin
        m_to   = 1'b0;
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_gnt;
    exp_gnt = (m_id < 0) ? 8'd0 : 8'(1 << m_id);
    check_val("gnt", arb.gnt, exp_gnt);
    check_val("gnt_id", arb.gnt_id, (m_id < 0) ? 0 : m_id);
    check_val("gnt_valid", arb.gnt_valid, (m_id >= 0));
    check_val("timeout", arb.timeout, m_to);
    check_val("onehot0", $onehot0(arb.gnt), 1);
    check_val("valid_eq_nz", arb.gnt_valid, (arb.gnt != 8'd0));
    check_val("to_consec", prev_to && arb.timeout, 0);
    prev_to = arb.timeout;
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, check at the next falling edge.
  task automatic cycle(input logic e, input logic [7:0] r, input logic d);
    arb.en   = e;
    arb.req  = r;
    arb.done = d;
    model_step(e, r, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    arb.en   = 1'b0;
    arb.req  = 8'd0;
    arb.done = 1'b0;
    rst      = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic       e;
    logic [7:0] r;
    logic       d;
    int         exp_id;

    rst = 1'b1;
    do_reset();

    // Two requesters, done pulse, then the next winner depends on policy.
    cycle(1'b1, 8'h84, 1'b0);
    check_val("r28_gnt", arb.gnt, 8'h80);
    check_val("r28_id", arb.gnt_id, 7);
    cycle(1'b1, 8'h84, 1'b1);
    check_val("r28_gap", arb.gnt, 8'h00);
    cycle(1'b1, 8'h84, 1'b0);
`ifdef ROUND_ROBIN_EN
    check_val("r28_next", arb.gnt, 8'h04);
`else
    check_val("r28_next", arb.gnt, 8'h80);
`endif

    // Hold-limit release with a timeout pulse, then regrant.
    do_reset();
    for (int i = 0; i < HOLD; i++) begin
      cycle(1'b1, 8'h10, 1'b0);
      check_val("r29_hold", arb.gnt, 8'h10);
    end
    cycle(1'b1, 8'h10, 1'b0);
    check_val("r29_rel", arb.gnt, 8'h00);
    check_val("r29_to", arb.timeout, 1);
    cycle(1'b1, 8'h10, 1'b0);
    check_val("r29_regnt", arb.gnt_id, 4);
    check_val("r29_to_off", arb.timeout, 0);

    // done in the same cycle as the hold limit suppresses the timeout.
    do_reset();
    for (int i = 0; i < HOLD; i++) cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b1, 8'h10, 1'b1);
    check_val("done_beats_to", arb.timeout, 0);

    // All requesting, done every grant.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, 8'hFF, 1'b0);
`ifdef ROUND_ROBIN_EN
      exp_id = (16 + 7 - k) % 8;
`else
      exp_id = 7;
`endif
      check_val("r30_seq", arb.gnt_id, exp_id);
      cycle(1'b1, 8'hFF, 1'b1);
      check_val("r30_gap", arb.gnt_valid, 0);
    end

    // Requester 3 withdraws, then enable drops.
    do_reset();
    cycle(1'b1, 8'h08, 1'b0);
    cycle(1'b1, 8'h08, 1'b0);
    check_val("r31_gnt3", arb.gnt, 8'h08);
    cycle(1'b1, 8'h00, 1'b0);
    check_val("r31_drop", arb.gnt, 8'h00);
    check_val("r31_to", arb.timeout, 0);
    cycle(1'b1, 8'h08, 1'b0);
    cycle(1'b0, 8'h08, 1'b0);
    check_val("r31_en", arb.gnt, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h08, 1'b0);
      check_val("r31_noregnt", arb.gnt, 8'h00);
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    cycle(1'b1, 8'h20, 1'b0);
    check_val("r32_gnt5", arb.gnt_id, 5);
    #2;
    rst = 1'b1;
    #1;
    check_val("r32_async_gnt", arb.gnt, 8'h00);
    check_val("r32_async_vld", arb.gnt_valid, 0);
    check_val("r32_async_id", arb.gnt_id, 0);
    model_reset();
    arb.req = 8'h01;
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    cycle(1'b1, 8'h01, 1'b0);
    check_val("r32_first", arb.gnt, 8'h01);

    // Randomized traffic against the model.
    do_reset();
    r = 8'($urandom);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) r = 8'($urandom);
      if ($urandom_range(0, 31) == 0) r = 8'd0;
      e = ($urandom_range(0, 15) != 0);
      d = ($urandom_range(0, 11) == 0);
      cycle(e, r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_arbiter8.md
PRIORITY_ARBITER8 -- requirements
Module: priority_arbiter8

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15, meaning the maximum number of consecutive cycles any single grant is held (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port en, input, 1, arbitration enable.
REQ-005 SHALL have port req, input, 8, request vector; bit n is requester n.
REQ-006 SHALL have port done, input, 1, current grantee finished; sampled only in GRANT.
REQ-007 SHALL have port gnt, output, 8, registered one-hot grant vector.
REQ-008 SHALL have port gnt_id, output, 3, registered binary index of the grantee, valid when gnt_valid=1.
REQ-009 SHALL have port gnt_valid, output, 1, registered; high exactly when gnt is non-zero.
REQ-010 SHALL have port timeout, output, 1, registered one-cycle pulse marking a forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 IDLE: when en=1 and req!=0, SHALL select a winner and enter GRANT; gnt, gnt_id and gnt_valid SHALL appear on the next edge (1-cycle latency from req to gnt).
REQ-013 IDLE with en=0 or req=0: SHALL stay in IDLE with gnt=0, gnt_id=0 and gnt_valid=0.
REQ-014 GRANT: SHALL hold gnt, gnt_id and gnt_valid unchanged while en=1, req[gnt_id]=1, done=0 and the hold count is below HOLD_MAX.
REQ-015 Hold counter: SHALL be 8 bits; SHALL load 1 on entry to GRANT and increment each further GRANT cycle; it SHALL never wrap.
REQ-016 GRANT SHALL release (next edge: IDLE, gnt=0, gnt_valid=0) on any of: done=1, req[gnt_id]=0, en=0, or hold count = HOLD_MAX.
REQ-017 timeout SHALL pulse high for exactly the first IDLE cycle after a release caused only by hold count = HOLD_MAX; done=1 in that same cycle takes precedence, giving no timeout.
REQ-018 After every release, SHALL spend at least one cycle in IDLE before the next grant, so back-to-back grants are separated by one gnt=0 cycle.
REQ-019 Changes on req bits other than gnt_id during GRANT SHALL NOT affect the current grant; there is no preemption.
REQ-020 gnt SHALL always be zero or one-hot, and gnt_id SHALL equal the encoded index of gnt.

Reset
REQ-021 rst=1 SHALL immediately, without waiting for clk, force state IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold count=0 and the round-robin pointer=0.
REQ-022 rst asserted mid-GRANT SHALL drop the grant asynchronously; after rst deasserts, the first grant SHALL take one full clk edge.

Configuration
REQ-023 Macro ROUND_ROBIN_EN SHALL select the winner-selection policy.
REQ-024 Without ROUND_ROBIN_EN: SHALL use fixed priority, req[7] highest down to req[0] lowest; no pointer register exists.
REQ-025 With ROUND_ROBIN_EN: a 3-bit pointer SHALL hold the last granted id (reset 0).
REQ-026 With ROUND_ROBIN_EN: the search SHALL start at (pointer-1) mod 8 and proceed in descending order with wrap, so after reset index 7 is highest, matching fixed mode.
REQ-027 With ROUND_ROBIN_EN: the pointer SHALL update to gnt_id on each entry to GRANT.

Verification
REQ-028 Reset then en=1, req=8'b1000_0100 held -> gnt=8'h80 and gnt_id=7 one cycle later; after done pulse, one idle cycle, then gnt=8'h04 (round-robin) or gnt=8'h80 again (fixed).
REQ-029 HOLD_MAX=15, req=8'h10 held, done=0 -> gnt=8'h10 for exactly 15 cycles, then gnt=0 with timeout=1 for one cycle, then regrant of id 4.
REQ-030 ROUND_ROBIN_EN, req=8'hFF held, done pulsed every grant -> gnt_id sequence 7,6,5,4,3,2,1,0,7 with one gnt=0 cycle between each.
REQ-031 Mid-grant of id 3: drop req[3] -> gnt=0 next edge with timeout=0; separately, drop en -> gnt=0 next edge and no regrant while en=0.
REQ-032 During GRANT of id 5, assert rst between clock edges -> gnt, gnt_valid and gnt_id go to 0 before the next edge; after release, req=8'h01 gives gnt=8'h01 one edge later.
REQ-033 On every cycle, assert that gnt is zero or one-hot, that gnt_valid equals (gnt!=0), and that timeout is never high on two consecutive cycles.
